game_ctrl: RTL and testbench

Top-level game sequencer for TOM-JERRY. It sits between the game-over detector and the rest of the game datapath: movement, cheese and drawing logic. It runs the game through its phases: title, position reset, play, round-end pause, and match-end. It counts round wins per player, freezes gameplay outside the play phase, and drives the screen-select code used by the draw mux.

---
 rtl/game_ctrl.sv | 135 +++++++++++++
 tb/tb_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// TOM-JERRY game sequencer: title, round init, play, round-end pause, match end.
// Tracks round wins and drives the freeze/reset/screen controls for the datapath.
module game_ctrl #(
  parameter int RST_CYCLES      = 2,
  parameter int END_HOLD_CYCLES = 120_000_000,
  parameter int WIN_ROUNDS      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic [1:0] gameover,
  output logic       game_rst,
  output logic       freeze,
  output logic [1:0] screen,
  output logic [3:0] tom_score,
  output logic [3:0] jerry_score,
  output logic [1:0] last_winner
);

  localparam int MAXN = (RST_CYCLES > END_HOLD_CYCLES)
                        ? RST_CYCLES : END_HOLD_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] END_LOAD = CW'(END_HOLD_CYCLES - 1);
  localparam logic [3:0]    WIN_N    = 4'(WIN_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    PLAY,
    ROUND_END,
    MATCH_END
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    tom_nx, jerry_nx;
  logic [1:0]    lw_nx;
  logic          start_q;
  logic          start_pe;

  // start_q resets high so a button held through reset is not an edge
  assign start_pe = btn_start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tom_score   <= '0;
      jerry_score <= '0;
      last_winner <= '0;
      start_q     <= 1'b1;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      tom_score   <= tom_nx;
      jerry_score <= jerry_nx;
      last_winner <= lw_nx;
      start_q     <= btn_start;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tom_nx   = tom_score;
    jerry_nx = jerry_score;
    lw_nx    = last_winner;
    unique case (state)
      IDLE: begin
        if (start_pe) begin
          tom_nx   = '0;
          jerry_nx = '0;
          lw_nx    = '0;
          cnt_nx   = RST_LOAD;
          state_nx = INIT;
        end
      end
      INIT: begin
        if (cnt == '0) state_nx = PLAY;
        else           cnt_nx   = cnt - 1'b1;
      end
      PLAY: begin
        if (gameover != 2'b00) begin
          // both bits set counts as a catch
          if (gameover[1]) begin
            lw_nx = 2'b10;
            if (tom_score != 4'hF) tom_nx = tom_score + 1'b1;
          end else begin
            lw_nx = 2'b01;
            if (jerry_score != 4'hF) jerry_nx = jerry_score + 1'b1;
          end
          cnt_nx   = END_LOAD;
          state_nx = ROUND_END;
        end
      end
      ROUND_END: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (tom_score == WIN_N || jerry_score == WIN_N) begin
          state_nx = MATCH_END;
        end else begin
          cnt_nx   = RST_LOAD;
          state_nx = INIT;
        end
      end
      MATCH_END: begin
        if (start_pe) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    game_rst = 1'b0;
    freeze   = 1'b1;
    screen   = 2'd0;
    unique case (state)
      IDLE:      screen = 2'd0;
      INIT: begin
        game_rst = 1'b1;
        screen   = 2'd1;
      end
      PLAY: begin
        freeze = 1'b0;
        screen = 2'd1;
      end
      ROUND_END: screen = 2'd2;
      MATCH_END: screen = 2'd3;
      default:   screen = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start edge, scoring, match end, async reset.
// Second instance runs a single-round match.
module tb_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_start;
  logic [1:0] gameover;
  logic       game_rst, freeze;
  logic [1:0] screen, last_winner;
  logic [3:0] tom_score, jerry_score;

  logic       btn1;
  logic [1:0] gov1;
  logic       game_rst1, freeze1;
  logic [1:0] screen1, last_winner1;
  logic [3:0] tom1, jerry1;

  int tests;
  int fails;

  game_ctrl #(
    .RST_CYCLES(2), .END_HOLD_CYCLES(4), .WIN_ROUNDS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start),
    .gameover(gameover), .game_rst(game_rst), .freeze(freeze),
    .screen(screen), .tom_score(tom_score),
    .jerry_score(jerry_score), .last_winner(last_winner)
  );

  game_ctrl #(
    .RST_CYCLES(2), .END_HOLD_CYCLES(4), .WIN_ROUNDS(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_start(btn1),
    .gameover(gov1), .game_rst(game_rst1), .freeze(freeze1),
    .screen(screen1), .tom_score(tom1),
    .jerry_score(jerry1), .last_winner(last_winner1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  task automatic win(input logic [1:0] go);
    gameover = go;
    step();
    gameover = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_start = 1'b1;
    gameover = 2'b00;
    btn1 = 1'b0;
    gov1 = 2'b00;
    repeat (3) step();
    tests++;
    if ({screen, freeze, game_rst, tom_score, jerry_score, last_winner}
        !== {2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0}) begin
      fails++;
      $display("FAIL reset_vals got %0d %b %b %0d %0d %0d", screen,
               freeze, game_rst, tom_score, jerry_score, last_winner);
    end
    rst_n = 1'b1;
    repeat (3) step();
    tests++;
    if ({screen, game_rst} !== {2'd0, 1'b0}) begin
      fails++;
      $display("FAIL held_no_start got screen=%0d game_rst=%b need 0 0",
               screen, game_rst);
    end
    btn_start = 1'b0;
    step();
    press();
    tests++;
    if ({screen, freeze, game_rst} !== {2'd1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL init_c1 got %0d %b %b need 1 1 1",
               screen, freeze, game_rst);
    end
    step();
    tests++;
    if (game_rst !== 1'b1) begin
      fails++;
      $display("FAIL init_c2 game_rst=%b need 1", game_rst);
    end
    step();
    tests++;
    if ({screen, freeze, game_rst} !== {2'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL play_entry got %0d %b %b need 1 0 0",
               screen, freeze, game_rst);
    end
  endtask

  task automatic test_tom_win();
    win(2'b10);
    tests++;
    if ({tom_score, last_winner, screen, freeze}
        !== {4'd1, 2'b10, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL tom_win got %0d %b %0d %b need 1 10 2 1",
               tom_score, last_winner, screen, freeze);
    end
    repeat (3) step();
    tests++;
    if (screen !== 2'd2) begin
      fails++;
      $display("FAIL hold_len screen=%0d need 2", screen);
    end
    step();
    tests++;
    if ({screen, game_rst} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL reinit got %0d %b need 1 1", screen, game_rst);
    end
    repeat (2) step();
  endtask

  task automatic test_match();
    for (int i = 0; i < 3; i++) begin
      win(2'b01);
      repeat (4) step();
      if (i < 2) repeat (2) step();
    end
    tests++;
    if ({screen, jerry_score, tom_score, last_winner}
        !== {2'd3, 4'd3, 4'd1, 2'b01}) begin
      fails++;
      $display("FAIL match_end got %0d %0d %0d %b need 3 3 1 01",
               screen, jerry_score, tom_score, last_winner);
    end
    step();
    press();
    tests++;
    if ({screen, jerry_score, tom_score} !== {2'd0, 4'd3, 4'd1}) begin
      fails++;
      $display("FAIL to_idle got %0d %0d %0d need 0 3 1",
               screen, jerry_score, tom_score);
    end
    step();
    press();
    tests++;
    if ({screen, game_rst, jerry_score, tom_score, last_winner}
        !== {2'd1, 1'b1, 4'd0, 4'd0, 2'd0}) begin
      fails++;
      $display("FAIL restart got %0d %b %0d %0d %0d need 1 1 0 0 0",
               screen, game_rst, jerry_score, tom_score, last_winner);
    end
    repeat (2) step();
  endtask

  task automatic test_both_bits();
    win(2'b11);
    tests++;
    if ({tom_score, jerry_score, last_winner}
        !== {4'd1, 4'd0, 2'b10}) begin
      fails++;
      $display("FAIL go11 got %0d %0d %b need 1 0 10",
               tom_score, jerry_score, last_winner);
    end
    gameover = 2'b01; step();
    gameover = 2'b10; step();
    gameover = 2'b11; step();
    gameover = 2'b00; step();
    tests++;
    if ({screen, game_rst, tom_score, jerry_score}
        !== {2'd1, 1'b1, 4'd1, 4'd0}) begin
      fails++;
      $display("FAIL end_ignore got %0d %b %0d %0d need 1 1 1 0",
               screen, game_rst, tom_score, jerry_score);
    end
    repeat (2) step();
  endtask

  task automatic test_start_ignored();
    press();
    step();
    tests++;
    if ({screen, freeze} !== {2'd1, 1'b0}) begin
      fails++;
      $display("FAIL start_in_play got %0d %b need 1 0", screen, freeze);
    end
    win(2'b01);
    press();
    step();
    tests++;
    if ({screen, jerry_score} !== {2'd2, 4'd1}) begin
      fails++;
      $display("FAIL start_in_end got %0d %0d need 2 1",
               screen, jerry_score);
    end
    repeat (2) step();
    tests++;
    if ({screen, game_rst} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL end_len got %0d %b need 1 1", screen, game_rst);
    end
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    win(2'b10);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({screen, freeze, game_rst, tom_score, jerry_score, last_winner}
        !== {2'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0}) begin
      fails++;
      $display("FAIL async_rst got %0d %b %b %0d %0d %0d", screen,
               freeze, game_rst, tom_score, jerry_score, last_winner);
    end
    step();
    rst_n = 1'b1;
    step();
    press();
    tests++;
    if ({screen, game_rst} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL rst_restart got %0d %b need 1 1", screen, game_rst);
    end
    repeat (2) step();
    tests++;
    if ({screen, freeze} !== {2'd1, 1'b0}) begin
      fails++;
      $display("FAIL rst_play got %0d %b need 1 0", screen, freeze);
    end
  endtask

  task automatic test_single_round();
    btn1 = 1'b1;
    step();
    btn1 = 1'b0;
    repeat (2) step();
    gov1 = 2'b01;
    step();
    gov1 = 2'b00;
    repeat (4) step();
    tests++;
    if ({screen1, jerry1, tom1, last_winner1}
        !== {2'd3, 4'd1, 4'd0, 2'b01}) begin
      fails++;
      $display("FAIL win1_match got %0d %0d %0d %b need 3 1 0 01",
               screen1, jerry1, tom1, last_winner1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_tom_win();
    test_match();
    test_both_bits();
    test_start_ignored();
    test_async_reset();
    test_single_round();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
